// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: instruction encodings, reset PC, FSM state codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSN_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES        = 32'd4;

  typedef enum logic [1:0] {
    FETCH_START  = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register with load enable, reset to RESET_VAL.
// Latency: loaded value visible one cycle after the enabled edge.
// Backpressure: holds its value whenever load_en is low.
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] load_val,
  output logic [31:0] pc
);

  // PC state: reset value, else load when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (load_en) begin
      pc <= load_val;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives PC to async-read imem, captures into IF/ID; stall/redirect/halt.
// Latency: inst_addr is combinational from PC; IF/ID updates one edge after the fetch.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall. Optional FETCH_PERF_CNT_EN adds counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT,
  parameter logic [31:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_next;
  logic         pc_load;
  logic         capture;
  logic         bubble;
  logic         halt_set;

  assign inst_addr = pc;
  assign pc_plus4  = pc + WORD_BYTES;

  fetch_unit_pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (pc_load),
    .load_val (pc_next),
    .pc       (pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-edge action select: redirect > stall > halt > capture.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_next   = pc;
    capture   = 1'b0;
    bubble    = 1'b0;
    halt_set  = 1'b0;
    case (state)
      FETCH_START: begin
        // One settle cycle for the memory at RESET_PC; nothing captured.
        state_nxt = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_next = word_align(redirect_target);
          bubble  = 1'b1;
        end else if (stall) begin
          // Hold everything.
        end else if (instruction == HALT_INSN) begin
          // Unknown bits make the compare non-true, so X words fall through to capture.
          bubble    = 1'b1;
          halt_set  = 1'b1;
          state_nxt = FETCH_HALTED;
        end else begin
          capture = 1'b1;
          pc_load = 1'b1;
          pc_next = pc_plus4;
        end
      end
      FETCH_HALTED: begin
        // Terminal until reset; stall and redirect are ignored.
      end
      default: begin
        state_nxt = FETCH_START;
      end
    endcase
  end

  // IF/ID pipeline register and sticky halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_inst     <= NOP_INSN;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      if (bubble) begin
        if_id_inst     <= NOP_INSN;
        if_id_pc_plus4 <= 32'h0000_0000;
        if_id_valid    <= 1'b0;
      end else if (capture) begin
        if_id_inst     <= instruction;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
      if (halt_set) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: captures and inserted bubbles, wrapping; stalls count nowhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= 32'h0000_0000;
      bubble_count <= 32'h0000_0000;
    end else begin
      if (capture) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an async-read memory model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises stall, redirect, halt, reset and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [0:31];

  localparam logic [31:0] WA = 32'h1111_1111;
  localparam logic [31:0] WB = 32'h2222_2222;
  localparam logic [31:0] WC = 32'h3333_3333;
  localparam logic [31:0] WD = 32'h4444_4444;
  localparam logic [31:0] W16 = 32'h5555_5555;
  localparam logic [31:0] W31 = 32'h7777_7777;

  // Asynchronous-read instruction memory, aliased over 32 words.
  assign instruction = mem[inst_addr[6:2]];

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .inst_addr       (inst_addr),
    .instruction     (instruction),
    .if_id_inst      (if_id_inst),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .bubble_count    (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep4,
                          input logic ev, input logic [31:0] ea);
    chk32({tag, "_inst"}, if_id_inst, ei);
    chk32({tag, "_pc4"}, if_id_pc_plus4, ep4);
    chk1({tag, "_valid"}, if_id_valid, ev);
    chk32({tag, "_addr"}, inst_addr, ea);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = WA;
    mem[1]  = WB;
    mem[2]  = WC;
    mem[3]  = WD;
    mem[4]  = 32'hFFFF_FFFF;
    mem[16] = W16;
    mem[31] = W31;

    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    #2;
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
    chk1("rst_halted", halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk32("rst_fcnt", fetch_count, 32'h0);
    chk32("rst_bcnt", bubble_count, 32'h0);
`endif
    rst_n = 1'b1;

    // Phase 1: start, sequential fetch, stall, redirect under stall.
    tick(); chk_ifid("start", 32'h0, 32'h0, 1'b0, 32'h0);
    tick(); chk_ifid("capA", WA, 32'd4, 1'b1, 32'd4);
    tick(); chk_ifid("capB", WB, 32'd8, 1'b1, 32'd8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ifid("stall", WB, 32'd8, 1'b1, 32'd8);
    end
    stall = 1'b0;
    tick(); chk_ifid("capC", WC, 32'd12, 1'b1, 32'd12);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0043;
    tick(); chk_ifid("redir", 32'h0, 32'h0, 1'b0, 32'h40);
    stall = 1'b0;
    redirect = 1'b0;
    tick(); chk_ifid("cap16", W16, 32'h44, 1'b1, 32'h44);
`ifdef FETCH_PERF_CNT_EN
    chk32("p1_fcnt", fetch_count, 32'd4);
    chk32("p1_bcnt", bubble_count, 32'd1);
`endif

    // Phase 2: asynchronous reset mid-run, then fetch into a HALT word.
    #1;
    rst_n = 1'b0;
    #1;
    chk_ifid("arst", 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick(); chk_ifid("start2", 32'h0, 32'h0, 1'b0, 32'h0);
    tick(); tick(); tick();
    tick(); chk_ifid("capD", WD, 32'd16, 1'b1, 32'd16);
    chk1("pre_halt", halted, 1'b0);
    tick(); chk_ifid("halt", 32'h0, 32'h0, 1'b0, 32'h10);
    chk1("halt_flag", halted, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk32("p2_fcnt", fetch_count, 32'd4);
    chk32("p2_bcnt", bubble_count, 32'd1);
`endif
    redirect = 1'b1;
    redirect_target = 32'h0000_0100;
    tick(); chk_ifid("halt_redir", 32'h0, 32'h0, 1'b0, 32'h10);
    redirect = 1'b0;
    stall = 1'b1;
    tick(); chk_ifid("halt_stall", 32'h0, 32'h0, 1'b0, 32'h10);
    chk1("halt_stay", halted, 1'b1);
    stall = 1'b0;

    // Phase 3: PC wrap, then redirect racing a HALT fetch.
    #1;
    rst_n = 1'b0;
    #1;
    chk1("arst_halt", halted, 1'b0);
    rst_n = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick(); chk_ifid("redir_top", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick(); chk_ifid("wrap", W31, 32'h0, 1'b1, 32'h0);
    redirect = 1'b1;
    redirect_target = 32'h0000_0010;
    tick(); chk32("to_halt_addr", inst_addr, 32'h10);
    redirect_target = 32'h0000_0008;
    tick(); chk_ifid("redir_over_halt", 32'h0, 32'h0, 1'b0, 32'h8);
    chk1("no_halt", halted, 1'b0);
    redirect = 1'b0;
    tick(); chk_ifid("capC2", WC, 32'd12, 1'b1, 32'd12);
`ifdef FETCH_PERF_CNT_EN
    chk32("p3_fcnt", fetch_count, 32'd2);
    chk32("p3_bcnt", bubble_count, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
